// File: rtl/snd_rdsched.sv
// rtl/snd_rdsched.sv - two-channel round-robin AXI read-burst scheduler for the sound IP
module snd_rdsched #(
    parameter int ADDR_W      = 29,
    parameter int BURST_BYTES = 128
) (
    input  logic              ACLK,
    input  logic              ARST,
    input  logic [1:0]        COMMAND,
    input  logic [1:0]        EN,
    input  logic [1:0]        LOOP,
    input  logic [ADDR_W-1:0] SNDADDR0,
    input  logic [ADDR_W-1:0] SNDADDR1,
    input  logic [ADDR_W-1:0] DATASIZE0,
    input  logic [ADDR_W-1:0] DATASIZE1,
    input  logic [1:0]        BUF_WREADY,
    output logic [ADDR_W-1:0] ARADDR,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic              RVALID,
    input  logic              RLAST,
    output logic              RREADY,
    output logic [1:0]        BUF_WR,
    output logic              CUR_CH,
    output logic              BUSY,
    output logic [1:0]        DONE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [1:0]        CMD_STOP  = 2'b00;
    localparam logic [1:0]        CMD_PLAY  = 2'b01;
    localparam logic [1:0]        CMD_CLEAR = 2'b11;
    localparam logic [ADDR_W:0]   BURST_W   = (ADDR_W+1)'(BURST_BYTES);

    state_t                   state_q, state_d;
    logic [1:0]               cmd_q;
    logic [1:0][ADDR_W-1:0]   base_q;
    logic [1:0][ADDR_W-1:0]   size_q;
    logic [1:0][ADDR_W-1:0]   offset_q;
    logic [1:0]               done_q;
    logic [1:0]               done_pulse_q;
    logic                     last_grant_q;
    logic                     cur_ch_q;
    logic [ADDR_W-1:0]        araddr_q;

    logic                     latch_now;
    logic                     halted;
    logic [1:0]               elig;
    logic                     grant_ch;
    logic                     do_grant;
    logic                     burst_end;
    logic [ADDR_W:0]          next_off;
    logic                     last_burst;

    // Fresh play (from stop or clear) latches new buffer parameters; that cycle
    // never grants so the first burst always uses the new base.
    assign latch_now  = (COMMAND == CMD_PLAY) && ((cmd_q == CMD_STOP) || (cmd_q == CMD_CLEAR));
    assign halted     = (COMMAND == CMD_STOP) || (COMMAND == CMD_CLEAR);
    assign burst_end  = (state_q == DATA) && RVALID && RLAST;
    assign next_off   = {1'b0, offset_q[cur_ch_q]} + BURST_W;
    assign last_burst = next_off >= {1'b0, size_q[cur_ch_q]};

    // Per-channel eligibility and round-robin arbitration against the last grant
    always_comb begin
        elig     = 2'b00;
        grant_ch = 1'b0;
        for (int n = 0; n < 2; n++) begin
            elig[n] = (COMMAND == CMD_PLAY) && !latch_now && EN[n] && BUF_WREADY[n]
                      && !done_q[n] && (size_q[n] != '0);
        end
        if (elig == 2'b11) begin
            grant_ch = ~last_grant_q;
        end else if (elig[1]) begin
            grant_ch = 1'b1;
        end
    end

    // State register
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d  = state_q;
        ARVALID  = 1'b0;
        RREADY   = 1'b0;
        BUSY     = 1'b0;
        BUF_WR   = 2'b00;
        do_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (elig != 2'b00) begin
                    do_grant = 1'b1;
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                ARVALID = 1'b1;
                if (ARREADY) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                RREADY = 1'b1;
                BUSY   = 1'b1;
                if (RVALID) begin
                    BUF_WR[cur_ch_q] = 1'b1;
                    if (RLAST) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Parameter latch, grant bookkeeping and per-channel offset/done tracking
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            cmd_q        <= CMD_STOP;
            base_q       <= '0;
            size_q       <= '0;
            offset_q     <= '0;
            done_q       <= 2'b00;
            done_pulse_q <= 2'b00;
            last_grant_q <= 1'b1;
            cur_ch_q     <= 1'b0;
            araddr_q     <= '0;
        end else begin
            cmd_q        <= COMMAND;
            done_pulse_q <= 2'b00;
            if (latch_now) begin
                base_q[0] <= SNDADDR0;
                base_q[1] <= SNDADDR1;
                size_q[0] <= DATASIZE0;
                size_q[1] <= DATASIZE1;
            end
            if (do_grant) begin
                cur_ch_q     <= grant_ch;
                last_grant_q <= grant_ch;
                araddr_q     <= base_q[grant_ch] + offset_q[grant_ch];
            end
            if (burst_end) begin
                if (last_burst) begin
                    if (LOOP[cur_ch_q]) begin
                        offset_q[cur_ch_q] <= '0;
                    end else begin
                        done_q[cur_ch_q]       <= 1'b1;
                        done_pulse_q[cur_ch_q] <= 1'b1;
                    end
                end else begin
                    offset_q[cur_ch_q] <= next_off[ADDR_W-1:0];
                end
            end
            // A fresh play, or stop/clear once no burst is in flight, rewinds both channels
            if (latch_now || (halted && (state_q == IDLE))) begin
                offset_q <= '0;
                done_q   <= 2'b00;
            end
        end
    end

    assign ARADDR = araddr_q;
    assign CUR_CH = cur_ch_q;
    assign DONE   = done_pulse_q;

endmodule

// File: doc/snd_rdsched.md
Name: snd_rdsched

Overview:
Two-requester AXI read-burst scheduler for the sound IP.
- Shares the single M_AXI read channel between two sample streams: ch0 is the main playback stream; ch1 is a second voice or effect stream.
- Issues fixed 32-beat × 32-bit bursts, round-robin, with at most one burst outstanding.
- Tracks a per-channel address, size and loop state.
- Routes read beats to the requesting channel's source buffer. Sits between snd_regctrl and the top-level AR/R channel.

Parameters:
- ADDR_W, 29, width of buffer address/size (byte units); top level prepends 3'b001.
- BURST_BYTES, 128, bytes per burst (32 beats × 4 bytes); must be a power of two.

Ports:
- ACLK  in  1  system clock
- ARST  in  1  synchronous active-high reset
- COMMAND  in  2  00 stop, 01 play, 10 pause, 11 clear
- EN  in  2  per-channel enable
- LOOP  in  2  per-channel loop enable
- SNDADDR0, SNDADDR1  in  ADDR_W  channel base address, byte units, BURST_BYTES-aligned
- DATASIZE0, DATASIZE1  in  ADDR_W  channel length in bytes
- BUF_WREADY  in  2  channel buffer has room for one full burst
- ARADDR  out  ADDR_W  burst address
- ARVALID  out  1  AR valid
- ARREADY  in  1  AR ready
- RVALID  in  1  read data valid
- RLAST  in  1  last beat of burst
- RREADY  out  1  read ready
- BUF_WR  out  2  per-channel beat write strobe
- CUR_CH  out  1  channel owning the current burst
- BUSY  out  1  burst in flight
- DONE  out  2  one-cycle pulse when a channel finishes its last non-looping burst

Behaviour:
- Reset state:
  - State IDLE.
  - ARVALID=0, RREADY=0, BUF_WR=0, BUSY=0, DONE=0, CUR_CH=0, ARADDR=0.
  - Offsets=0, done flags=0, last-grant pointer=1 (ch0 wins first).
- Parameter latch:
  - SNDADDRn and DATASIZEn are captured into internal registers on the cycle COMMAND changes to 01 from 00 or 11.
  - Changes to these inputs during play/pause are ignored.
- Eligibility: channel n is eligible when COMMAND==01 && EN[n] && BUF_WREADY[n] && !done[n] && size[n]!=0.
- States:
  - IDLE:
    - If any channel is eligible: grant, set CUR_CH, drive ARADDR=base+offset, go to ADDR (ARVALID=1 from the next cycle).
    - Grant rule: if both are eligible, grant the channel ≠ last-grant pointer; update the pointer on grant.
  - ADDR:
    - ARVALID=1 and ARADDR held stable until ARREADY.
    - On ARVALID&&ARREADY: go to DATA, with ARVALID=0 in the next cycle.
  - DATA:
    - RREADY=1 and BUSY=1.
    - BUF_WR[CUR_CH]=RVALID&&RREADY, combinational.
    - On RVALID&&RLAST: go to IDLE and apply the offset update below.
- Offset update (at RLAST):
  - If offset+BURST_BYTES ≥ size (last burst): with LOOP set, offset←0 and no DONE; otherwise done flag←1 and DONE[CUR_CH] pulses for one cycle.
  - Else offset←offset+BURST_BYTES.
  - Size not a multiple of BURST_BYTES is rounded up: the last burst is issued in full.
- Minimum gap: one IDLE cycle between bursts (RLAST → next ARVALID takes 2 cycles).
- Pause (10) / stop (00) / clear (11) mid-burst:
  - An AR already presented is held until accepted.
  - The burst is always drained to RLAST; no abort.
  - No new grants are made.
- Stop or clear:
  - Once back in IDLE, offsets←0 and done flags←0.
  - Pause keeps offsets, so resume continues at the next burst.
- EN[n] dropped mid-burst: the burst completes; the channel is not granted again while low. Its offset is retained.
- BUF_WREADY deasserting during DATA does not stall RREADY. The buffer guarantees space for one burst when it asserts BUF_WREADY.
- RVALID while not in DATA: ignored, RREADY=0.
- ARST mid-operation: returns to reset state next cycle. The interconnect is reset by the same ARESETN.

Test Plan:
- Single channel, no loop: ch0 only, SNDADDR0=0x1000, DATASIZE0=0x200, play → ARADDR 0x1000, 0x1080, 0x1100, 0x1180. 32 BUF_WR[0] pulses per burst, DONE[0] one cycle after the 4th RLAST, then idle.
- Round-robin: both channels enabled, ch0 base 0x1000, ch1 base 0x8000, BUF_WREADY=11 → grants ch0, ch1, ch0, ch1. ARADDR 0x1000, 0x8000, 0x1080, 0x8080. BUF_WR routes only to CUR_CH.
- Loop and short size: ch1 LOOP=1, DATASIZE1=0x90 → ARADDR 0x8000, 0x8080, 0x8000, … with DONE never pulsing. DATASIZE=0x40 gives a repeating single burst at 0x8000.
- Pause mid-burst then stop:
  - Pause during beat 10 → remaining beats are accepted, no further AR; resume → next ARADDR=previous+0x80.
  - Stop → after RLAST, offset is 0 and a new play restarts at base.
- Handshake stress: ARREADY delayed 5 cycles and RVALID randomly gapped → ARADDR stable while ARVALID=1, exactly 32 BUF_WR per burst, BUF_WREADY=0 blocks grant, and ARST mid-DATA clears all outputs next cycle.
